// File: rtl/ps2_kbd_tx_pkg.sv
// Shared types, line levels and frame helpers for the PS/2 keyboard transmitter.
// Purely combinational definitions; no timing or backpressure of their own.
package ps2_kbd_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CLK_HI,
        CLK_LO,
        GAP
    } state_t;

    localparam int unsigned FRAME_LEN     = 11;
    // A host inhibit seen before this many falling edges aborts the frame.
    localparam int unsigned INHIBIT_LIMIT = 10;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Bit 0 goes out first: start, data LSB..MSB, parity, stop.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] d);
        return {STOP_LVL, odd_parity(d), d, START_LVL};
    endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Scan-code byte handshake into the transmitter: valid/ready, byte taken when both high.
// No storage; ready reflects free space in the transmitter buffer.
interface ps2_kbd_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO with occupancy count; head visible combinationally, push lands next edge.
// Refuses pushes when full (contents untouched); simultaneous push and pop keep the count unchanged.
module ps2_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     i_push_vld,
    input  logic [7:0]               i_push_dat,
    output logic                     o_push_rdy,
    input  logic                     i_pop,
    output logic [7:0]               o_head_dat,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_push_rdy = (r_count < (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign w_push     = i_push_vld && o_push_rdy;
    assign w_pop      = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: buffered scan codes sent as 11-bit frames; start bit 1 clk after launch.
// Backpressure via in_ready; PS2_KBD_TX_FIFO_EN selects a FIFO_DEPTH FIFO, else a single holding register.
module ps2_kbd_tx
    import ps2_kbd_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 25,
    parameter int unsigned GAP_CYC    = 50,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         clrn,
    ps2_kbd_tx_if.slave                  bus,
    input  logic                         host_inhibit,
    output logic                         ps2_clk,
    output logic                         ps2_data,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int unsigned CNT_MAX  = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int unsigned DW       = $clog2(CNT_MAX);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYC - 1);

    state_t                 r_state;
    state_t                 w_nxt_state;
    logic [DW-1:0]          r_div;
    logic [DW-1:0]          w_nxt_div;
    logic [3:0]             r_edges;
    logic [3:0]             w_nxt_edges;
    logic                   r_retx;
    logic                   w_nxt_retx;
    logic [FRAME_LEN-1:0]   r_frame;
    logic                   r_ps2_clk;
    logic                   r_ps2_data;
    logic                   w_nxt_clk;
    logic                   w_nxt_data;
    logic                   w_pop;
    logic                   w_load;
    logic                   w_abort;
    logic                   w_have;
    logic [7:0]             w_head;

`ifdef PS2_KBD_TX_FIFO_EN
    logic w_empty;

    ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .clrn       (clrn),
        .i_push_vld (bus.in_valid),
        .i_push_dat (bus.in_data),
        .o_push_rdy (bus.in_ready),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_empty    (w_empty),
        .o_count    (fifo_count)
    );
    assign w_have = !w_empty;
`else
    logic       r_hold_vld;
    logic [7:0] r_hold_dat;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_hold_vld <= 1'b0;
            r_hold_dat <= '0;
        end else if (bus.in_valid && !r_hold_vld) begin
            r_hold_vld <= 1'b1;
            r_hold_dat <= bus.in_data;
        end else if (w_pop) begin
            r_hold_vld <= 1'b0;
        end
    end

    assign bus.in_ready = !r_hold_vld;
    assign w_have       = r_hold_vld;
    assign w_head       = r_hold_dat;
    assign fifo_count   = {{$clog2(FIFO_DEPTH){1'b0}}, r_hold_vld};
`endif

    // r_edges counts completed falling edges of the current frame.
    assign w_abort  = host_inhibit && (r_edges < 4'(INHIBIT_LIMIT));
    assign ps2_clk  = r_ps2_clk;
    assign ps2_data = r_ps2_data;
    assign busy     = (r_state != IDLE) || r_retx;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_div   = r_div;
        w_nxt_edges = r_edges;
        w_nxt_retx  = r_retx;
        w_nxt_clk   = r_ps2_clk;
        w_nxt_data  = r_ps2_data;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_nxt_clk  = IDLE_LVL;
                w_nxt_data = IDLE_LVL;
                if (w_have && !host_inhibit) begin
                    w_nxt_state = SETUP;
                    w_nxt_data  = START_LVL;
                end
            end
            SETUP: begin
                // A retransmit reuses the latched frame; only fresh frames consume the buffer.
                w_pop       = !r_retx;
                w_load      = !r_retx;
                w_nxt_div   = '0;
                w_nxt_edges = '0;
                if (host_inhibit) begin
                    w_nxt_state = GAP;
                    w_nxt_retx  = 1'b1;
                    w_nxt_clk   = IDLE_LVL;
                    w_nxt_data  = IDLE_LVL;
                end else begin
                    w_nxt_state = CLK_HI;
                    w_nxt_retx  = 1'b0;
                end
            end
            CLK_HI: begin
                if (w_abort) begin
                    w_nxt_state = GAP;
                    w_nxt_retx  = 1'b1;
                    w_nxt_div   = '0;
                    w_nxt_clk   = IDLE_LVL;
                    w_nxt_data  = IDLE_LVL;
                end else if (r_div == DIV_LAST) begin
                    w_nxt_state = CLK_LO;
                    w_nxt_div   = '0;
                    w_nxt_clk   = 1'b0;
                    w_nxt_edges = r_edges + 4'd1;
                end else begin
                    w_nxt_div = r_div + 1'b1;
                end
            end
            CLK_LO: begin
                if (w_abort) begin
                    w_nxt_state = GAP;
                    w_nxt_retx  = 1'b1;
                    w_nxt_div   = '0;
                    w_nxt_clk   = IDLE_LVL;
                    w_nxt_data  = IDLE_LVL;
                end else if (r_div == DIV_LAST) begin
                    w_nxt_div = '0;
                    w_nxt_clk = 1'b1;
                    if (r_edges == 4'(FRAME_LEN)) begin
                        w_nxt_state = GAP;
                        w_nxt_data  = IDLE_LVL;
                    end else begin
                        w_nxt_state = CLK_HI;
                        w_nxt_data  = r_frame[r_edges];
                    end
                end else begin
                    w_nxt_div = r_div + 1'b1;
                end
            end
            GAP: begin
                w_nxt_clk  = IDLE_LVL;
                w_nxt_data = IDLE_LVL;
                // A pending retransmit needs GAP_CYC consecutive cycles of released inhibit.
                if (r_retx && host_inhibit) begin
                    w_nxt_div = '0;
                end else if (r_div == GAP_LAST) begin
                    w_nxt_div = '0;
                    if (r_retx) begin
                        w_nxt_state = SETUP;
                        w_nxt_data  = START_LVL;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end else begin
                    w_nxt_div = r_div + 1'b1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_edges    <= '0;
            r_retx     <= 1'b0;
            r_frame    <= {FRAME_LEN{IDLE_LVL}};
            r_ps2_clk  <= IDLE_LVL;
            r_ps2_data <= IDLE_LVL;
        end else begin
            r_state    <= w_nxt_state;
            r_div      <= w_nxt_div;
            r_edges    <= w_nxt_edges;
            r_retx     <= w_nxt_retx;
            r_ps2_clk  <= w_nxt_clk;
            r_ps2_data <= w_nxt_data;
            if (w_load) begin
                r_frame <= build_frame(w_head);
            end
        end
    end

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25: ps2_clk half-period in clk cycles, minimum 2.
REQ-002 SHALL have parameter GAP_CYC, default 50: idle clk cycles between consecutive frames.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: scan-code FIFO depth, power of two.
REQ-004 SHALL have one clock and an asynchronous active-low reset; ports `clk` and `clrn`.
REQ-005 Port list (name, direction, width, meaning):
- `clk` in 1: system clock.
- `clrn` in 1: asynchronous active-low reset.
- `in_data` in 8: scan code to send.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: FIFO can accept a byte.
- `host_inhibit` in 1: host holds the line; frames must not start.
- `ps2_clk` out 1: device-generated PS/2 clock, idles high.
- `ps2_data` out 1: PS/2 data, idles high.
- `busy` out 1: frame in progress or retransmit pending.
- `fifo_count` out log2(FIFO_DEPTH)+1: bytes queued.

Function
REQ-006 Byte SHALL be accepted on a rising `clk` edge when `in_valid` and `in_ready` are both high.
REQ-007 `in_ready` SHALL equal (`fifo_count` < FIFO_DEPTH).
REQ-008 When the FIFO is full, the input byte SHALL NOT be accepted and FIFO contents SHALL be unchanged.
REQ-009 Frame format SHALL be 11 bits: start 0, data[0]..data[7] (LSB first), odd parity, stop 1.
REQ-010 Odd parity SHALL be chosen so the count of ones over data plus parity is odd.
REQ-011 FSM states SHALL be IDLE, SETUP, CLK_HI, CLK_LO and GAP.
REQ-012 IDLE -> SETUP when the FIFO is non-empty and `host_inhibit` is low; SETUP pops the head byte and latches the frame.
REQ-013 In SETUP, `ps2_data` SHALL show the start bit 1 clk after the IDLE exit decision.
REQ-014 CLK_HI lasts CLK_DIV cycles with `ps2_clk` high; then CLK_LO lasts CLK_DIV cycles with `ps2_clk` low.
REQ-015 `ps2_data` SHALL change only on the CLK_LO -> CLK_HI transition, so it is stable across every falling edge.
REQ-016 Exactly 11 falling edges per frame; after the 11th CLK_LO, go to GAP with both lines high.
REQ-017 GAP lasts GAP_CYC cycles, then IDLE.
REQ-018 A byte accepted in the same cycle as a pop SHALL be queued with no loss; `fifo_count` is unchanged net.
REQ-019 If `host_inhibit` rises before the 10th falling edge:
- abort the frame and drive both lines high next cycle;
- keep the byte for retransmit and keep `busy` high;
- resend the whole frame from SETUP once `host_inhibit` has been low for GAP_CYC cycles.
REQ-020 If `host_inhibit` rises at or after the 10th falling edge, the frame SHALL complete normally.
REQ-021 `busy` SHALL be high in every state except IDLE, and high during a pending retransmit.

Reset
REQ-022 On `clrn` low, asynchronously:
- `ps2_clk` = 1, `ps2_data` = 1, `busy` = 0;
- FIFO emptied, `fifo_count` = 0, `in_ready` = 1;
- FSM = IDLE and all counters cleared.
REQ-023 Reset mid-frame SHALL discard the frame and the FIFO; nothing is resent after release.

Configuration
REQ-024 Macro PS2_KBD_TX_FIFO_EN selects the buffering:
- defined: FIFO of FIFO_DEPTH entries;
- undefined: single holding register, `in_ready` = !full, `fifo_count` is 0 or 1, FIFO_DEPTH ignored;
- frame timing is identical in both cases.

Structure
REQ-025 A shared package SHALL hold:
- the FSM state enum;
- frame length constant 11;
- start, stop and idle line levels;
- the odd-parity function.
REQ-026 The FIFO SHALL be the sub-module ps2_tx_fifo (sync FIFO, count output); the FSM, divider and shifter stay in ps2_kbd_tx.

Verification
REQ-027 Push 8'h1C, loop back into the PS/2 receiver, read `ps2_data` at each falling edge:
- expect 0,0,0,1,1,1,0,0,0,0,1 (parity 0);
- receiver `data` = 8'h1C, `overflow` = 0.
REQ-028 Push 8'hF0, 8'h1C back-to-back:
- expect two frames; F0 parity bit = 1;
- gap of at least GAP_CYC cycles between the 11th edge and the next start bit;
- receiver reads F0 then 1C.
REQ-029 With `host_inhibit` = 1, push 9 bytes:
- `in_ready` falls after the 8th, `fifo_count` = 8, 9th byte dropped, no ps2_clk edges;
- release: 8 frames arrive in order.
REQ-030 Assert `host_inhibit` after the 5th falling edge of 8'h1B:
- both lines high the next cycle;
- after release plus GAP_CYC, the full 8'h1B frame is resent and the receiver gets a single 8'h1B.
REQ-031 Pull `clrn` low mid-frame:
- lines go high, `busy` = 0, `fifo_count` = 0 with no `clk` edge needed;
- after release, no spurious frame.
